// File: rtl/im_arbiter_pkg.sv
// Shared types and widths for the instruction-memory arbiter.
// IM_ARBITER_PERF_EN enables the optional grant/conflict counters.
package im_arbiter_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Which requester received the most recent grant.
  typedef enum logic {
    PTR_FETCH = 1'b0,
    PTR_LOAD  = 1'b1
  } ptr_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/im_arbiter_if.sv
// Requester and memory-side signal bundle for im_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface im_arbiter_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 10
);

  logic                 fetch_req;
  logic [ADDR_SIZE-1:0] fetch_addr;
  logic                 fetch_gnt;
  logic                 fetch_valid;
  logic [DATA_SIZE-1:0] fetch_data;

  logic                 load_req;
  logic [ADDR_SIZE-1:0] load_addr;
  logic [DATA_SIZE-1:0] load_data;
  logic                 load_gnt;
  logic                 load_done;

  logic                 IM_enable;
  logic                 IM_read;
  logic                 IM_write;
  logic [ADDR_SIZE-1:0] IM_address;
  logic [DATA_SIZE-1:0] IMin;
  logic [DATA_SIZE-1:0] instruction;

  logic                 boot_mode;

  modport slave (
    input  fetch_req, fetch_addr, load_req, load_addr, load_data, load_done, instruction,
    output fetch_gnt, fetch_valid, fetch_data, load_gnt,
    output IM_enable, IM_read, IM_write, IM_address, IMin, boot_mode
  );

  modport master (
    output fetch_req, fetch_addr, load_req, load_addr, load_data, load_done, instruction,
    input  fetch_gnt, fetch_valid, fetch_data, load_gnt,
    input  IM_enable, IM_read, IM_write, IM_address, IMin, boot_mode
  );

endinterface

// File: rtl/im_rr_sel.sv
// Two-way round-robin selector: one-hot grant {load, fetch}; on a tie the
// requester that was not granted last wins.
module im_rr_sel
  import im_arbiter_pkg::*;
(
  input  logic       req_fetch_i,
  input  logic       req_load_i,
  input  ptr_e       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_fetch_i && req_load_i) begin
      gnt_o = (last_i == PTR_LOAD) ? 2'b01 : 2'b10;
    end else if (req_fetch_i) begin
      gnt_o = 2'b01;
    end else if (req_load_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/im_arbiter.sv
// Instruction-memory arbiter: loader-only BOOT phase, then round-robin between
// CPU fetch and loader. Define IM_ARBITER_PERF_EN for rd/wr/conflict counters.
module im_arbiter
  import im_arbiter_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 10
) (
  input  logic clk,
  input  logic rst,
  im_arbiter_if.slave bus
`ifdef IM_ARBITER_PERF_EN
  ,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] conflict_count
`endif
);

  state_e               state_q, state_d;
  ptr_e                 last_q, last_d;
  logic                 fetch_valid_q;
  logic [DATA_SIZE-1:0] fetch_data_q;
  logic [1:0]           rr_gnt_c;
  logic                 fetch_gnt_c, load_gnt_c;
  logic [ADDR_SIZE-1:0] im_addr_c;
  logic [DATA_SIZE-1:0] im_wdata_c;

  im_rr_sel u_rr_sel (
    .req_fetch_i (bus.fetch_req),
    .req_load_i  (bus.load_req),
    .last_i      (last_q),
    .gnt_o       (rr_gnt_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_BOOT;
      last_q        <= PTR_LOAD;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      fetch_valid_q <= fetch_gnt_c;
      if (fetch_valid_q) begin
        fetch_data_q <= bus.instruction;
      end
    end
  end

  // Next state and grants; grants are forced low while reset is held.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    fetch_gnt_c = 1'b0;
    load_gnt_c  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        load_gnt_c = bus.load_req;
        if (bus.load_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        fetch_gnt_c = rr_gnt_c[0];
        load_gnt_c  = rr_gnt_c[1];
        if (rr_gnt_c[0]) begin
          last_d = PTR_FETCH;
        end else if (rr_gnt_c[1]) begin
          last_d = PTR_LOAD;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    if (!rst) begin
      fetch_gnt_c = 1'b0;
      load_gnt_c  = 1'b0;
    end
  end

  always_comb begin
    im_addr_c  = '0;
    im_wdata_c = '0;
    if (fetch_gnt_c) begin
      im_addr_c = bus.fetch_addr;
    end else if (load_gnt_c) begin
      im_addr_c  = bus.load_addr;
      im_wdata_c = bus.load_data;
    end
  end

  assign bus.fetch_gnt   = fetch_gnt_c;
  assign bus.load_gnt    = load_gnt_c;
  assign bus.IM_enable   = fetch_gnt_c | load_gnt_c;
  assign bus.IM_read     = fetch_gnt_c;
  assign bus.IM_write    = load_gnt_c;
  assign bus.IM_address  = im_addr_c;
  assign bus.IMin        = im_wdata_c;
  assign bus.boot_mode   = (state_q == ST_BOOT);
  assign bus.fetch_valid = fetch_valid_q;
  // Memory read data arrives the cycle after the grant; hold it afterwards.
  assign bus.fetch_data  = fetch_valid_q ? bus.instruction : fetch_data_q;

`ifdef IM_ARBITER_PERF_EN
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q, cf_cnt_q;
  logic             conflict_c;

  assign conflict_c = (state_q == ST_RUN) && bus.fetch_req && bus.load_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      cf_cnt_q <= '0;
    end else begin
      rd_cnt_q <= sat_inc(rd_cnt_q, fetch_gnt_c);
      wr_cnt_q <= sat_inc(wr_cnt_q, load_gnt_c);
      cf_cnt_q <= sat_inc(cf_cnt_q, conflict_c);
    end
  end

  assign rd_count       = rd_cnt_q;
  assign wr_count       = wr_cnt_q;
  assign conflict_count = cf_cnt_q;
`endif

endmodule

// File: tb/tb_im_arbiter.sv
// Directed bench for im_arbiter with a small synchronous-read memory model.
module tb_im_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;

  im_arbiter_if #(.DATA_SIZE(32), .ADDR_SIZE(10)) bus ();

`ifdef IM_ARBITER_PERF_EN
  logic [15:0] rd_count, wr_count, conflict_count;
`endif

  im_arbiter #(.DATA_SIZE(32), .ADDR_SIZE(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IM_ARBITER_PERF_EN
    ,
    .rd_count       (rd_count),
    .wr_count       (wr_count),
    .conflict_count (conflict_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];

  always @(posedge clk) begin
    if (bus.IM_enable && bus.IM_write) mem[bus.IM_address] <= bus.IMin;
    if (bus.IM_enable && bus.IM_read)  bus.instruction <= mem[bus.IM_address];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic freq, input logic [9:0] faddr, input logic lreq,
                       input logic [9:0] laddr, input logic [31:0] ldata, input logic ldone);
    @(negedge clk);
    bus.fetch_req  = freq;
    bus.fetch_addr = faddr;
    bus.load_req   = lreq;
    bus.load_addr  = laddr;
    bus.load_data  = ldata;
    bus.load_done  = ldone;
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic fg, input logic lg);
    chk({tag, "_fgnt"}, 64'(bus.fetch_gnt), 64'(fg));
    chk({tag, "_lgnt"}, 64'(bus.load_gnt), 64'(lg));
    chk({tag, "_rw"}, 64'(bus.IM_read & bus.IM_write), 64'(0));
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.load_req  = 1'b1; bus.load_addr  = '0; bus.load_data = '0;
    bus.load_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with a load request held to show grants stay low
    chk("rst_boot",   64'(bus.boot_mode), 64'(1));
    chk("rst_fvalid", 64'(bus.fetch_valid), 64'(0));
    chk("rst_fdata",  64'(bus.fetch_data), 64'(0));
    chk("rst_en",     64'(bus.IM_enable), 64'(0));
    chk_gnt("rst", 1'b0, 1'b0);

    // First load in BOOT
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 10'h000, 1'b1, 10'h080, 32'h1234_5678, 1'b0);
    chk_gnt("ld0", 1'b0, 1'b1);
    chk("ld0_wr",   64'(bus.IM_write), 64'(1));
    chk("ld0_addr", 64'(bus.IM_address), 64'h080);
    chk("ld0_din",  64'(bus.IMin), 64'h1234_5678);

    // Fetch requests are blocked in BOOT
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 10'h080, 1'b0, 10'h000, 32'h0, 1'b0);
      chk("boot_fgnt", 64'(bus.fetch_gnt), 64'(0));
      chk("boot_rd",   64'(bus.IM_read), 64'(0));
    end

    // load_done together with a load
    drive(1'b0, 10'h000, 1'b1, 10'h081, 32'hCAFE_F00D, 1'b1);
    chk_gnt("ldd", 1'b0, 1'b1);
    chk("ldd_addr", 64'(bus.IM_address), 64'h081);
    chk("ldd_boot", 64'(bus.boot_mode), 64'(1));
    drive(1'b0, 10'h000, 1'b0, 10'h000, 32'h0, 1'b0);
    chk("run_boot", 64'(bus.boot_mode), 64'(0));
    chk("run_idle_en", 64'(bus.IM_enable), 64'(0));

    // Both requesting: fetch, load, fetch, load
    drive(1'b1, 10'h080, 1'b1, 10'h100, 32'hA5A5_0100, 1'b0);
    chk_gnt("rr1", 1'b1, 1'b0);
    chk("rr1_addr", 64'(bus.IM_address), 64'h080);
    chk("rr1_fv",   64'(bus.fetch_valid), 64'(0));
    drive(1'b1, 10'h081, 1'b1, 10'h100, 32'hA5A5_0100, 1'b0);
    chk_gnt("rr2", 1'b0, 1'b1);
    chk("rr2_addr", 64'(bus.IM_address), 64'h100);
    chk("rr2_fv",   64'(bus.fetch_valid), 64'(1));
    chk("rr2_fd",   64'(bus.fetch_data), 64'h1234_5678);
    drive(1'b1, 10'h081, 1'b1, 10'h101, 32'hA5A5_0101, 1'b0);
    chk_gnt("rr3", 1'b1, 1'b0);
    chk("rr3_fv",   64'(bus.fetch_valid), 64'(0));
    chk("rr3_fd",   64'(bus.fetch_data), 64'h1234_5678);
    drive(1'b1, 10'h081, 1'b1, 10'h101, 32'hA5A5_0101, 1'b0);
    chk_gnt("rr4", 1'b0, 1'b1);
    chk("rr4_fv",   64'(bus.fetch_valid), 64'(1));
    chk("rr4_fd",   64'(bus.fetch_data), 64'hCAFE_F00D);
    drive(1'b0, 10'h000, 1'b0, 10'h000, 32'h0, 1'b0);
    chk_gnt("idle", 1'b0, 1'b0);
    chk("idle_fv",   64'(bus.fetch_valid), 64'(0));
    chk("idle_fd",   64'(bus.fetch_data), 64'hCAFE_F00D);
    chk("idle_addr", 64'(bus.IM_address), 64'h0);
    chk("idle_din",  64'(bus.IMin), 64'h0);

    // Back-to-back fetches of the words written in RUN
    drive(1'b1, 10'h100, 1'b0, 10'h000, 32'h0, 1'b0);
    chk_gnt("b2b1", 1'b1, 1'b0);
    drive(1'b1, 10'h101, 1'b0, 10'h000, 32'h0, 1'b0);
    chk_gnt("b2b2", 1'b1, 1'b0);
    chk("b2b2_fv", 64'(bus.fetch_valid), 64'(1));
    chk("b2b2_fd", 64'(bus.fetch_data), 64'hA5A5_0100);
    drive(1'b1, 10'h080, 1'b0, 10'h000, 32'h0, 1'b0);
    chk_gnt("b2b3", 1'b1, 1'b0);
    chk("b2b3_fv", 64'(bus.fetch_valid), 64'(1));
    chk("b2b3_fd", 64'(bus.fetch_data), 64'hA5A5_0101);
    drive(1'b0, 10'h000, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 1'b0);
    chk_gnt("ldrun", 1'b0, 1'b1);
    chk("ldrun_addr", 64'(bus.IM_address), 64'h3FF);
    chk("ldrun_din",  64'(bus.IMin), 64'hDEAD_BEEF);
    chk("ldrun_fv",   64'(bus.fetch_valid), 64'(1));
    chk("ldrun_fd",   64'(bus.fetch_data), 64'h1234_5678);

    // load_done in RUN has no effect
    drive(1'b0, 10'h000, 1'b0, 10'h000, 32'h0, 1'b1);
    drive(1'b0, 10'h000, 1'b0, 10'h000, 32'h0, 1'b0);
    chk("ign_done_boot", 64'(bus.boot_mode), 64'(0));

    // Reset right after a fetch grant drops the pending response
    drive(1'b1, 10'h080, 1'b0, 10'h000, 32'h0, 1'b0);
    chk_gnt("prerst", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.fetch_req = 1'b0;
    #1;
    chk("rst_mid_fv",   64'(bus.fetch_valid), 64'(0));
    chk("rst_mid_boot", 64'(bus.boot_mode), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 10'h000, 1'b0, 10'h000, 32'h0, 1'b0);
      chk("post_rst_fv",   64'(bus.fetch_valid), 64'(0));
      chk("post_rst_boot", 64'(bus.boot_mode), 64'(1));
    end

`ifdef IM_ARBITER_PERF_EN
    // 3 fetch grants, 2 load grants, 2 conflict cycles
    drive(1'b0, 10'h000, 1'b0, 10'h000, 32'h0, 1'b1);
    drive(1'b1, 10'h080, 1'b1, 10'h200, 32'h1, 1'b0);
    drive(1'b1, 10'h081, 1'b1, 10'h200, 32'h1, 1'b0);
    drive(1'b1, 10'h080, 1'b0, 10'h000, 32'h0, 1'b0);
    drive(1'b1, 10'h081, 1'b0, 10'h000, 32'h0, 1'b0);
    drive(1'b0, 10'h000, 1'b1, 10'h201, 32'h2, 1'b0);
    drive(1'b0, 10'h000, 1'b0, 10'h000, 32'h0, 1'b0);
    chk("perf_rd", 64'(rd_count), 64'd3);
    chk("perf_wr", 64'(wr_count), 64'd2);
    chk("perf_cf", 64'(conflict_count), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/im_arbiter.md
IM_ARBITER -- requirements
Module: im_arbiter

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 10, instruction-memory word address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports fetch_req input 1, fetch_addr input ADDR_SIZE, fetch_gnt output 1, fetch_valid output 1, fetch_data output DATA_SIZE: CPU fetch requester.
REQ-006 SHALL have ports load_req input 1, load_addr input ADDR_SIZE, load_data input DATA_SIZE, load_gnt output 1, load_done input 1: program-loader requester; load_done is a one-cycle pulse that ends boot.
REQ-007 SHALL have ports IM_enable, IM_read, IM_write output 1; IM_address output ADDR_SIZE; IMin output DATA_SIZE; instruction input DATA_SIZE: memory side.
REQ-008 SHALL have port boot_mode output 1, high while in BOOT state.

Function
REQ-009 SHALL implement FSM states BOOT and RUN; BOOT->RUN on load_done=1; RUN has no exit except reset.
REQ-010 SHALL in BOOT grant only the loader: load_gnt=load_req, fetch_gnt=0.
REQ-011 SHALL in RUN arbitrate round-robin: one requester pending -> grant it; both pending -> grant the one not granted last; last-grant pointer updates only on a grant.
REQ-012 SHALL drive memory controls combinationally in the grant cycle: fetch grant -> IM_enable=1, IM_read=1, IM_write=0, IM_address=fetch_addr; load grant -> IM_enable=1, IM_write=1, IM_read=0, IM_address=load_addr, IMin=load_data; no grant -> IM_enable=IM_read=IM_write=0, IM_address=0, IMin=0.
REQ-013 SHALL never assert IM_read and IM_write together, nor fetch_gnt and load_gnt together.
REQ-014 SHALL assert fetch_valid exactly one cycle after each fetch grant, with fetch_data=instruction in that cycle; fetch_data SHALL hold its last value otherwise.
REQ-015 SHALL support back-to-back fetch grants, giving one fetch_valid per cycle at one-cycle latency.
REQ-016 SHALL, when load_done and load_req coincide in BOOT, grant that load in the same cycle and enter RUN at the next edge.
REQ-017 SHALL ignore load_done while in RUN.
REQ-018 SHALL treat requesters as non-blocking: a requester not granted holds req, addr and data stable until granted.

Reset
REQ-019 SHALL, while rst=0, force state=BOOT, last-grant pointer=load (fetch wins first RUN tie), fetch_valid=0, fetch_data=0, boot_mode=1, and all grants and IM controls 0.
REQ-020 SHALL, on reset mid-operation, drop any pending fetch response (no fetch_valid after rst deasserts for a pre-reset grant).

Configuration
REQ-021 SHALL, with macro IM_ARBITER_PERF_EN defined, add outputs rd_count, wr_count, conflict_count (16 bits each, saturating at 16'hFFFF, reset 0) counting fetch grants, load grants, and cycles with both requests pending in RUN.
REQ-022 SHALL, without IM_ARBITER_PERF_EN, omit these ports and counters entirely, all other behaviour identical.

Structure
REQ-023 SHALL place FSM state encoding (BOOT=1'b0, RUN=1'b1), grant-pointer encoding and counter width in shared package im_arbiter_pkg.
REQ-024 SHALL implement the two-way round-robin selection as sub-module im_rr_sel (inputs: two requests, pointer; outputs: one-hot grant).

Verification
REQ-025 SHALL check: reset, then load_req with load_addr=0x080, load_data=0x12345678 -> load_gnt=1, IM_write=1, IM_address=0x080, IMin=0x12345678 same cycle.
REQ-026 SHALL check: in BOOT, fetch_req=1 for 10 cycles -> fetch_gnt=0, IM_read=0 throughout.
REQ-027 SHALL check: load_done+load_req together -> that write granted, boot_mode=0 next cycle.
REQ-028 SHALL check: in RUN, both requesting 4 cycles -> grants fetch,load,fetch,load; fetch_valid one cycle after each fetch grant, fetch_data equal to instruction.
REQ-029 SHALL check: rst asserted in the cycle after a fetch grant -> fetch_valid stays 0; state BOOT after release.
REQ-030 SHALL check (IM_ARBITER_PERF_EN): 3 fetch grants, 2 load grants, 2 conflict cycles -> rd_count=3, wr_count=2, conflict_count=2.
